multi_channel_debouncer: RTL and testbench

- Per-channel glitch/debounce filter; generalises the fixed-width shift-register filter to N independent channels.
- Each channel has a counter-based stability window, run-time programmable threshold, input synchroniser and registered edge-detect outputs.
- Sits between raw external inputs (buttons, opto-isolated lines, noisy status pins) and synchronous control logic.

---
 rtl/multi_channel_debouncer.sv | 89 ++++++++
 tb/tb_multi_channel_debouncer.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multi_channel_debouncer.sv
// multi_channel_debouncer: per-channel synchroniser + counter debounce with registered rise/fall pulses (glitch status under DEBOUNCE_GLITCH_STATUS_EN)
module multi_channel_debouncer #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [CNT_W-1:0]    threshold,
    input  logic [CHANNELS-1:0] din,
`ifdef DEBOUNCE_GLITCH_STATUS_EN
    input  logic                glitch_clr,
    output logic [CHANNELS-1:0] glitch_flag,
`endif
    output logic [CHANNELS-1:0] dout,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall
);
    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CHANNELS-1:0]                  s, dout_q, dout_d, rise_q, rise_d, fall_q, fall_d;

    assign s    = sync_q[SYNC_STAGES-1];
    assign dout = dout_q;
    assign rise = rise_q;
    assign fall = fall_q;

    // Synchroniser chain, free-running so it stays current while filtering is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= '0;
        else begin
            sync_q[0] <= din;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
        end
    end

    // Debounce decision: reset count on agreement, accept once the count reaches the threshold
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (!enable || s[c] == dout_q[c]) cnt_d[c] = '0;
            else if (cnt_q[c] >= threshold) begin
                cnt_d[c]  = '0;
                dout_d[c] = s[c];
                rise_d[c] = s[c];
                fall_d[c] = ~s[c];
            end
            else cnt_d[c] = cnt_q[c] + 1'b1;
        end
    end

    // Filter state and edge pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

`ifdef DEBOUNCE_GLITCH_STATUS_EN
    logic [CHANNELS-1:0] glitch_q, glitch_d;

    assign glitch_flag = glitch_q;

    // Sticky rejected-pulse flags; a same-cycle set beats the clear, frozen while disabled
    always_comb begin
        glitch_d = glitch_q;
        for (int c = 0; c < CHANNELS; c++)
            if (enable) glitch_d[c] = (glitch_q[c] & ~glitch_clr) | (s[c] == dout_q[c] && cnt_q[c] != '0);
    end

    // Glitch flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) glitch_q <= '0;
        else glitch_q <= glitch_d;
    end
`endif
endmodule

// File: tb/tb_multi_channel_debouncer.sv
// tb_multi_channel_debouncer: directed sequence with a cycle model feeding a scoreboard queue, plus spec-latency spot checks
module tb_multi_channel_debouncer;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int OW = 4 * CH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b1;
    logic [CW-1:0] threshold = 8'd3;
    logic [CH-1:0] din = '0;
    logic [CH-1:0] dout, rise, fall;
    logic          glitch_clr = 1'b0;
`ifdef DEBOUNCE_GLITCH_STATUS_EN
    logic [CH-1:0] glitch_flag;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    logic [CH-1:0] m_s0 = '0, m_s1 = '0, m_dout = '0, m_rise = '0, m_fall = '0, m_glitch = '0;
    int            m_cnt [CH] = '{default: 0};
    logic [OW-1:0] sb [$];
    logic [CH-1:0] frozen;
    logic          seen;

    always #5 clk = ~clk;

    multi_channel_debouncer #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .threshold  (threshold),
        .din        (din),
`ifdef DEBOUNCE_GLITCH_STATUS_EN
        .glitch_clr (glitch_clr),
        .glitch_flag(glitch_flag),
`endif
        .dout       (dout),
        .rise       (rise),
        .fall       (fall)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] observed();
`ifdef DEBOUNCE_GLITCH_STATUS_EN
        return {glitch_flag, fall, rise, dout};
`else
        return {{CH{1'b0}}, fall, rise, dout};
`endif
    endfunction

    function automatic logic [OW-1:0] expected();
`ifdef DEBOUNCE_GLITCH_STATUS_EN
        return {m_glitch, m_fall, m_rise, m_dout};
`else
        return {{CH{1'b0}}, m_fall, m_rise, m_dout};
`endif
    endfunction

    // One clock edge of the reference behaviour, using the inputs as they stand before the edge
    task automatic model_step();
        logic [CH-1:0] s, set;
        if (!rst_n) begin
            m_s0 = '0; m_s1 = '0; m_dout = '0; m_rise = '0; m_fall = '0; m_glitch = '0;
            foreach (m_cnt[c]) m_cnt[c] = 0;
        end else begin
            s = m_s1; m_s1 = m_s0; m_s0 = din;
            m_rise = '0; m_fall = '0; set = '0;
            for (int c = 0; c < CH; c++) begin
                if (!enable) m_cnt[c] = 0;
                else if (s[c] == m_dout[c]) begin
                    set[c] = (m_cnt[c] != 0);
                    m_cnt[c] = 0;
                end else if (m_cnt[c] >= int'(threshold)) begin
                    m_dout[c] = s[c];
                    m_rise[c] = s[c];
                    m_fall[c] = ~s[c];
                    m_cnt[c] = 0;
                end else m_cnt[c]++;
            end
            if (enable) m_glitch = (glitch_clr ? '0 : m_glitch) | set;
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            model_step();
            sb.push_back(expected());
            @(posedge clk);
            @(negedge clk);
            check("scoreboard", 32'(observed()), 32'(sb.pop_front()));
        end
    endtask

    initial begin
        #1;
        check("reset_dout", 32'(dout), 0);
        check("reset_pulses", 32'({rise, fall}), 0);
        tick(2);
        rst_n = 1'b1;
        tick(3);
        // short excursion of 3 cycles at T=3 is rejected
        din[0] = 1'b1; tick(3); din[0] = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            seen |= rise[0] | dout[0];
        end
        check("short_pulse_rejected", 32'(seen), 0);
        // held high: dout follows exactly 6 edges later, then held low
        din[0] = 1'b1; tick(5);
        check("hold_rise_early", 32'(dout[0]), 0);
        tick();
        check("hold_rise_dout", 32'(dout[0]), 1);
        check("hold_rise_pulse", 32'(rise[0]), 1);
        tick();
        check("rise_one_cycle", 32'(rise[0]), 0);
        tick(3);
        din[0] = 1'b0; tick(5);
        check("hold_fall_early", 32'(dout[0]), 1);
        tick();
        check("hold_fall_dout", 32'(dout[0]), 0);
        check("hold_fall_pulse", 32'({fall[0], rise[0]}), 2);
        tick();
        check("fall_one_cycle", 32'(fall[0]), 0);
        // T=0 bypass: one-cycle pulse passes through with 3-edge delay
        threshold = 8'd0; tick(3);
        din[0] = 1'b1; tick(); din[0] = 1'b0; tick();
        check("bypass_delay", 32'(dout[0]), 0);
        tick();
        check("bypass_rise", 32'({dout[0], rise[0]}), 3);
        tick();
        check("bypass_fall", 32'({dout[0], fall[0]}), 1);
        // lowering T mid-count accepts on the next edge; channel 2 toggling stays rejected
        threshold = 8'd10; tick(2);
        din[1] = 1'b1;
        for (int k = 0; k < 7; k++) begin
            din[2] = ~din[2];
            tick();
        end
        check("t_change_before", 32'(dout[1]), 0);
        threshold = 8'd2; tick();
        check("t_change_accept", 32'({dout[1], rise[1]}), 3);
        check("toggle_ch_rejected", 32'(dout[2]), 0);
        din[2] = 1'b0; tick(2);
        // disabled: outputs frozen while inputs churn
        enable = 1'b0; frozen = dout;
        for (int k = 0; k < 20; k++) begin
            din = CH'($urandom);
            tick();
            check("frozen_dout", 32'(dout), 32'(frozen));
            check("frozen_pulses", 32'({rise, fall}), 0);
        end
        enable = 1'b1; din = '0; threshold = 8'd0; tick(5);
        check("reenable_settle", 32'(dout), 0);
        // async reset mid-count, then rise after 11 edges from release
        threshold = 8'd8; din[3] = 1'b1; tick(6);
        rst_n = 1'b0; #1;
        check("async_reset_out", 32'({dout, rise, fall}), 0);
        tick();
        rst_n = 1'b1; tick(10);
        check("post_reset_early", 32'(dout[3]), 0);
        tick();
        check("post_reset_rise", 32'({dout[3], rise[3]}), 3);
        din = '0; threshold = 8'd0; tick(4);
`ifdef DEBOUNCE_GLITCH_STATUS_EN
        check("glitch_idle", 32'(glitch_flag), 0);
        threshold = 8'd5;
        din[0] = 1'b1; tick(2); din[0] = 1'b0; tick(6);
        check("glitch_set", 32'(glitch_flag[0]), 1);
        glitch_clr = 1'b1; tick(); glitch_clr = 1'b0;
        check("glitch_clr", 32'(glitch_flag), 0);
        tick(2);
`endif
        check("sb_empty", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
